// File: rtl/lzrw1_token_sequencer_if.sv
// Stream-side and decompressor-side handshake bundle for lzrw1_token_sequencer.
// master = stream source / decompressor side, slave = sequencer.
interface lzrw1_token_sequencer_if;
    logic [15:0] in_word;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] dec_data;
    logic        dec_control_word;
    logic        dec_in_valid;
    logic        dec_busy;

    modport master (
        output in_word, in_valid, in_last, dec_busy,
        input  in_ready, dec_data, dec_control_word, dec_in_valid
    );

    modport slave (
        input  in_word, in_valid, in_last, dec_busy,
        output in_ready, dec_data, dec_control_word, dec_in_valid
    );
endinterface

// File: rtl/lzrw1_token_sequencer.sv
// LZRW1 control-word/item parser issuing one item per decompressor transaction.
// Optional statistics counters enabled by defining LZRW1_SEQ_STATS_EN.
module lzrw1_token_sequencer #(
    parameter int unsigned ITEMS_PER_GROUP = 16
`ifdef LZRW1_SEQ_STATS_EN
   ,parameter int unsigned CNT_WIDTH       = 16
`endif
) (
    input  logic                    clock_i,
    input  logic                    reset_ni,
    input  logic                    start_i,
    lzrw1_token_sequencer_if.slave  bus,
    output logic                    seq_busy_o,
    output logic                    done_o,
    output logic                    error_o
`ifdef LZRW1_SEQ_STATS_EN
   ,output logic [CNT_WIDTH-1:0]    lit_count_o,
    output logic [CNT_WIDTH-1:0]    copy_count_o
`endif
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] FETCH_CTRL = 3'd1;
    localparam logic [2:0] FETCH_ITEM = 3'd2;
    localparam logic [2:0] ISSUE      = 3'd3;
    localparam logic [2:0] GUARD      = 3'd4;
    localparam logic [2:0] DONE       = 3'd5;

    localparam logic [3:0] LAST_IDX = 4'(ITEMS_PER_GROUP - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] flags_q, flags_d;
    logic [3:0]  idx_q,   idx_d;
    logic [15:0] word_q,  word_d;
    logic        flag_q,  flag_d;
    logic        last_q,  last_d;
    logic        error_q, error_d;
    logic        len_zero;
    logic        issue_ok;

`ifdef LZRW1_SEQ_STATS_EN
    logic [CNT_WIDTH-1:0] lit_q,  lit_d;
    logic [CNT_WIDTH-1:0] copy_q, copy_d;
`endif

    // A copy with a zero length field is rejected instead of being issued.
    assign len_zero = flag_q && (word_q[15:12] == 4'd0);
    assign issue_ok = (state_q == ISSUE) && !bus.dec_busy && !len_zero;

    assign bus.in_ready         = (state_q == FETCH_CTRL) || (state_q == FETCH_ITEM);
    assign bus.dec_in_valid     = issue_ok;
    assign bus.dec_data         = word_q;
    assign bus.dec_control_word = flag_q;
    assign seq_busy_o           = (state_q != IDLE);
    assign done_o               = (state_q == DONE);
    assign error_o              = error_q;

    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        idx_d   = idx_q;
        word_d  = word_q;
        flag_d  = flag_q;
        last_d  = last_q;
        error_d = error_q;
`ifdef LZRW1_SEQ_STATS_EN
        lit_d   = lit_q;
        copy_d  = copy_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    error_d = 1'b0;
`ifdef LZRW1_SEQ_STATS_EN
                    lit_d   = '0;
                    copy_d  = '0;
`endif
                    state_d = FETCH_CTRL;
                end
            end
            FETCH_CTRL: begin
                if (bus.in_valid) begin
                    flags_d = bus.in_word;
                    idx_d   = '0;
                    state_d = bus.in_last ? DONE : FETCH_ITEM;
                end
            end
            FETCH_ITEM: begin
                if (bus.in_valid) begin
                    word_d  = bus.in_word;
                    flag_d  = flags_q[idx_q];
                    last_d  = bus.in_last;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (len_zero) begin
                    error_d = 1'b1;
                    state_d = GUARD;
                end else if (!bus.dec_busy) begin
                    state_d = GUARD;
                end
            end
            GUARD: begin
                if (last_q) begin
                    state_d = DONE;
                end else if (idx_q == LAST_IDX) begin
                    state_d = FETCH_CTRL;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = FETCH_ITEM;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef LZRW1_SEQ_STATS_EN
        if (issue_ok) begin
            if (flag_q) begin
                if (copy_q != '1) copy_d = copy_q + CNT_WIDTH'(1);
            end else begin
                if (lit_q != '1) lit_d = lit_q + CNT_WIDTH'(1);
            end
        end
`endif
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            flags_q <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            flag_q  <= 1'b0;
            last_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef LZRW1_SEQ_STATS_EN
            lit_q   <= '0;
            copy_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            flag_q  <= flag_d;
            last_q  <= last_d;
            error_q <= error_d;
`ifdef LZRW1_SEQ_STATS_EN
            lit_q   <= lit_d;
            copy_q  <= copy_d;
`endif
        end
    end

`ifdef LZRW1_SEQ_STATS_EN
    assign lit_count_o  = lit_q;
    assign copy_count_o = copy_q;
`endif

endmodule

// File: tb/tb_lzrw1_token_sequencer.sv
// Directed bench for lzrw1_token_sequencer with a stream-level expectation model.
module tb_lzrw1_token_sequencer;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic seq_busy, done, error;
`ifdef LZRW1_SEQ_STATS_EN
    logic [15:0] lit_count, copy_count;
`endif

    lzrw1_token_sequencer_if bus();

    lzrw1_token_sequencer #(.ITEMS_PER_GROUP(16)) dut (
        .clock_i    (clock),
        .reset_ni   (reset_n),
        .start_i    (start),
        .bus        (bus),
        .seq_busy_o (seq_busy),
        .done_o     (done),
        .error_o    (error)
`ifdef LZRW1_SEQ_STATS_EN
       ,.lit_count_o  (lit_count),
        .copy_count_o (copy_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] data;
        logic        flag;
    } item_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    item_t exp_q[$];
    int strobe_t[$];
    int done_t = 0;
    int prev_strobe = -100;
    item_t cmp_e;
    logic [15:0] blk_w[$];
    logic exp_err;
    int exp_lit, exp_copy;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected issue list derived from the stream: control word, then items
    // taking flags LSB first, a new control word after every 16 items.
    task automatic model();
        logic [15:0] fl;
        int idx;
        logic need;
        item_t it;
        exp_q.delete();
        exp_err = 1'b0; exp_lit = 0; exp_copy = 0;
        need = 1'b1; idx = 0; fl = '0;
        foreach (blk_w[i]) begin
            if (need) begin
                fl = blk_w[i]; idx = 0; need = 1'b0;
            end else begin
                it.flag = fl[idx];
                it.data = blk_w[i];
                if (it.flag && blk_w[i][15:12] == 4'd0) exp_err = 1'b1;
                else begin
                    exp_q.push_back(it);
                    if (it.flag) exp_copy++; else exp_lit++;
                end
                idx++;
                if (idx == 16) need = 1'b1;
            end
        end
    endtask

    always @(negedge clock) begin
        if (done) done_t = cyc;
        if (bus.dec_in_valid) begin
            strobe_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_strobe: got data %0h, none expected", bus.dec_data);
            end else begin
                cmp_e = exp_q.pop_front();
                check("dec_data", 32'(bus.dec_data), 32'(cmp_e.data));
                check("dec_control_word", 32'(bus.dec_control_word), 32'(cmp_e.flag));
                check("in_ready_during_issue", 32'(bus.in_ready), 32'd0);
                if (prev_strobe >= 0)
                    check("strobe_gap_ge3", 32'(cyc - prev_strobe >= 3), 32'd1);
            end
            prev_strobe = cyc;
        end
        if (!seq_busy) prev_strobe = -100;
    end

    task automatic send(input logic [15:0] w, input logic l);
        int n;
        logic r;
        bus.in_word = w; bus.in_last = l; bus.in_valid = 1'b1;
        n = 0; r = 1'b0;
        while (!r && n < 100) begin
            @(negedge clock);
            r = bus.in_ready;
            tick();
            n++;
        end
        check("send_accepted", 32'(r), 32'd1);
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        logic got;
        n = 0; got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clock);
            if (done) got = 1'b1;
            tick();
            n++;
        end
        check("done_seen", 32'(got), 32'd1);
        @(negedge clock);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(seq_busy), 32'd0);
        check("all_items_issued", 32'(exp_q.size()), 32'd0);
        check("error_flag", 32'(error), 32'(exp_err));
`ifdef LZRW1_SEQ_STATS_EN
        check("lit_count", 32'(lit_count), 32'(exp_lit));
        check("copy_count", 32'(copy_count), 32'(exp_copy));
`endif
        tick();
    endtask

    task automatic run_block(input logic bp);
        model();
        strobe_t.delete();
        start = 1'b1; tick(); start = 1'b0;
        @(negedge clock);
        check("error_clear_on_start", 32'(error), 32'd0);
        check("busy_after_start", 32'(seq_busy), 32'd1);
`ifdef LZRW1_SEQ_STATS_EN
        check("lit_clear_on_start", 32'(lit_count), 32'd0);
        check("copy_clear_on_start", 32'(copy_count), 32'd0);
`endif
        tick();
        foreach (blk_w[i]) begin
            if (bp && i == 1) bus.dec_busy = 1'b1;
            send(blk_w[i], i == blk_w.size() - 1);
            if (bp && i == 1) begin
                for (int k = 0; k < 6; k++) begin
                    @(negedge clock);
                    check("bp_no_strobe", 32'(bus.dec_in_valid), 32'd0);
                    check("bp_not_ready", 32'(bus.in_ready), 32'd0);
                    if (k == 2) start = 1'b1;
                    tick();
                    start = 1'b0;
                end
                bus.dec_busy = 1'b0;
            end
        end
        wait_done();
    endtask

    initial begin
        bus.in_word = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.dec_busy = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_seq_busy", 32'(seq_busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_dec_in_valid", 32'(bus.dec_in_valid), 32'd0);
        check("rst_dec_data", 32'(bus.dec_data), 32'd0);
        tick();

        // Valid while idle and no start is ignored.
        bus.in_valid = 1'b1; bus.in_word = 16'h1234;
        @(negedge clock);
        check("idle_ignores_valid", 32'(bus.in_ready), 32'd0);
        tick();
        bus.in_valid = 1'b0;

        // Literals only, exact 3-cycle spacing, done two cycles after last strobe.
        blk_w = '{16'h0000, 16'h0041, 16'h0042, 16'h0043};
        run_block(1'b0);
        check("lit_strobe_count", 32'(strobe_t.size()), 32'd3);
        if (strobe_t.size() == 3) begin
            check("lit_gap1", 32'(strobe_t[1] - strobe_t[0]), 32'd3);
            check("lit_gap2", 32'(strobe_t[2] - strobe_t[1]), 32'd3);
            check("done_after_guard", 32'(done_t - strobe_t[2]), 32'd2);
        end

        // Mixed flags; pin the model against hand-derived items first.
        blk_w = '{16'h0002, 16'h0061, 16'h3005};
        model();
        check("model_size", 32'(exp_q.size()), 32'd2);
        check("model_d0", 32'(exp_q[0].data), 32'h0061);
        check("model_f0", 32'(exp_q[0].flag), 32'd0);
        check("model_d1", 32'(exp_q[1].data), 32'h3005);
        check("model_f1", 32'(exp_q[1].flag), 32'd1);
        run_block(1'b0);

        // Early last with remaining flag bits set.
        blk_w = '{16'hFFFE, 16'h0011};
        run_block(1'b0);

        // Backpressure with an ignored start while busy.
        blk_w = '{16'h0000, 16'h0077};
        run_block(1'b1);
        check("bp_strobe_count", 32'(strobe_t.size()), 32'd1);

        // Group rollover: second control word must not be forwarded.
        blk_w.delete();
        blk_w.push_back(16'h0000);
        for (int i = 0; i < 16; i++) blk_w.push_back(16'h0100 + 16'(i));
        blk_w.push_back(16'hFFFF);
        blk_w.push_back(16'h4010);
        run_block(1'b0);
        check("roll_strobe_count", 32'(strobe_t.size()), 32'd17);

        // Empty group terminated by last on the control word.
        blk_w = '{16'h00FF};
        run_block(1'b0);
        check("empty_strobe_count", 32'(strobe_t.size()), 32'd0);

        // Zero-length copy is rejected and error stays set until the next start.
        blk_w = '{16'h0001, 16'h0123};
        run_block(1'b0);
        check("inv_strobe_count", 32'(strobe_t.size()), 32'd0);
        repeat (3) tick();
        @(negedge clock);
        check("error_sticky", 32'(error), 32'd1);
        tick();

`ifdef LZRW1_SEQ_STATS_EN
        blk_w = '{16'h000A, 16'h0061, 16'h3005, 16'h0062, 16'h2007};
        run_block(1'b0);
        check("stats_model_lit", 32'(exp_lit), 32'd2);
        check("stats_model_copy", 32'(exp_copy), 32'd2);
`endif

        // Reset while parked in ISSUE.
        exp_q.delete();
        start = 1'b1; tick(); start = 1'b0;
        send(16'h0000, 1'b0);
        bus.dec_busy = 1'b1;
        send(16'h0055, 1'b0);
        @(negedge clock);
        check("parked_no_strobe", 32'(bus.dec_in_valid), 32'd0);
        check("parked_dec_data", 32'(bus.dec_data), 32'h0055);
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        bus.dec_busy = 1'b0;
        @(negedge clock);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("mid_rst_seq_busy", 32'(seq_busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_error", 32'(error), 32'd0);
        check("mid_rst_dec_in_valid", 32'(bus.dec_in_valid), 32'd0);
        check("mid_rst_dec_data", 32'(bus.dec_data), 32'd0);
        check("mid_rst_dec_flag", 32'(bus.dec_control_word), 32'd0);
        tick();

        // Normal operation resumes after the reset.
        blk_w = '{16'h0002, 16'h0061, 16'h3005};
        run_block(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
